// File: rtl/jpeg_pkg.sv
// Shared types and constants for the RGB block buffer and its bank storage.
// The buffer gathers 8x8 blocks of RGB pixels, indexed k = row*8 + col.
package jpeg_pkg;

    localparam int PIX_W   = 8;
    localparam int BLK_PIX = 64;
    localparam int CNT_W   = 16;
    localparam int IDX_W   = 6;

    // One pixel as it travels from the input port into a bank entry.
    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_pix_t;

    // Position of a pixel inside its block.
    typedef logic [IDX_W-1:0] blk_idx_t;

    localparam blk_idx_t LAST_IDX = blk_idx_t'(BLK_PIX - 1);

    // Steps a block index forward by one pixel; wraps to 0 after the last pixel.
    function automatic blk_idx_t next_idx(input blk_idx_t idx);
        return (idx == LAST_IDX) ? '0 : blk_idx_t'(idx + 1'b1);
    endfunction

endpackage

// File: rtl/rgb_block_bank.sv
// One 64-entry block store. A single pixel is written per cycle at the given
// index; all entries are read out in parallel as separate R/G/B arrays.
// Reset clears every entry, so a freshly reset bank reads as all zeros.
module rgb_block_bank
    import jpeg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  blk_idx_t         wr_idx,
    input  rgb_pix_t         wr_pix,
    output logic [PIX_W-1:0] rd_r [BLK_PIX],
    output logic [PIX_W-1:0] rd_g [BLK_PIX],
    output logic [PIX_W-1:0] rd_b [BLK_PIX]
);

    rgb_pix_t mem_q [BLK_PIX];
    rgb_pix_t mem_d [BLK_PIX];

    // Next contents: unchanged except for the single entry being written.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_pix;
        end
    end

    // Entry storage, cleared asynchronously so outputs read zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BLK_PIX; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Split the packed entries into the per-component read arrays.
    always_comb begin
        for (int i = 0; i < BLK_PIX; i++) begin
            rd_r[i] = mem_q[i].r;
            rd_g[i] = mem_q[i].g;
            rd_b[i] = mem_q[i].b;
        end
    end

endmodule

// File: rtl/rgb_block_buffer.sv
// Ping-pong buffer that collects a serial RGB pixel stream (8x8 block order)
// into complete 64-pixel blocks and presents the held block as parallel
// oR/oG/oB arrays for the colour-conversion stage.
// Optional feature: define RGB_BUF_SYNC_CHECK_EN to add the in_sob
// start-of-block input and the registered sync_err flag; without it blocks
// are delimited purely by pixel count.
module rgb_block_buffer
    import jpeg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
`ifdef RGB_BUF_SYNC_CHECK_EN
    input  logic             in_sob,
    output logic             sync_err,
`endif
    output logic [PIX_W-1:0] oR [BLK_PIX],
    output logic [PIX_W-1:0] oG [BLK_PIX],
    output logic [PIX_W-1:0] oB [BLK_PIX],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] blk_cnt
);

    logic [1:0]       full_q,    full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    blk_idx_t         wr_idx_q,  wr_idx_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    logic             accept;
    logic             release_blk;
    blk_idx_t         wr_pos;
    logic             wr_last;
    rgb_pix_t         in_pix;
    logic             bank_we [2];

    logic [PIX_W-1:0] bank_r [2][BLK_PIX];
    logic [PIX_W-1:0] bank_g [2][BLK_PIX];
    logic [PIX_W-1:0] bank_b [2][BLK_PIX];

    // Handshakes: a full write bank stalls the input, a full read bank is offered.
    always_comb begin
        in_ready    = !full_q[wr_bank_q];
        out_valid   = full_q[rd_bank_q];
        accept      = in_valid && in_ready;
        release_blk = out_valid && out_ready;
        in_pix      = '{r: in_r, g: in_g, b: in_b};
    end

`ifdef RGB_BUF_SYNC_CHECK_EN
    logic sync_err_q, sync_err_d;

    // A start-of-block marker restarts the block at index 0, dropping any partial fill.
    always_comb begin
        wr_pos     = (in_sob) ? '0 : wr_idx_q;
        sync_err_d = accept && ((in_sob && (wr_idx_q != '0)) ||
                                (!in_sob && (wr_idx_q == '0)));
    end

    // One-cycle flag for a marker that disagrees with the pixel count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= sync_err_d;
        end
    end

    assign sync_err = sync_err_q;
`else
    // Without markers the write position is simply the running pixel count.
    always_comb begin
        wr_pos = wr_idx_q;
    end
`endif

    // Pointer, full-flag and counter updates; fill completion and release hit different banks.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        blk_cnt_d = blk_cnt_q;
        wr_last   = (wr_pos == LAST_IDX);

        if (release_blk) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            blk_cnt_d         = blk_cnt_q + 1'b1;
        end

        if (accept) begin
            wr_idx_d = next_idx(wr_pos);
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            blk_cnt_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Route the accepted pixel to whichever bank is currently filling.
    always_comb begin
        bank_we[0] = accept && (wr_bank_q == 1'b0);
        bank_we[1] = accept && (wr_bank_q == 1'b1);
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        rgb_block_bank u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (bank_we[b]),
            .wr_idx (wr_pos),
            .wr_pix (in_pix),
            .rd_r   (bank_r[b]),
            .rd_g   (bank_g[b]),
            .rd_b   (bank_b[b])
        );
    end

    // Present the held bank directly; it cannot change until it is released.
    always_comb begin
        for (int k = 0; k < BLK_PIX; k++) begin
            oR[k] = bank_r[rd_bank_q][k];
            oG[k] = bank_g[rd_bank_q][k];
            oB[k] = bank_b[rd_bank_q][k];
        end
    end

    assign blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_rgb_block_buffer.sv
// Directed bench for rgb_block_buffer: reset, streaming, back-pressure,
// simultaneous fill/release, mid-block reset and (when RGB_BUF_SYNC_CHECK_EN
// is defined) start-of-block resynchronisation.
module tb_rgb_block_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_r;
    logic [7:0]  in_g;
    logic [7:0]  in_b;
    logic [7:0]  o_r [64];
    logic [7:0]  o_g [64];
    logic [7:0]  o_b [64];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] blk_cnt;
`ifdef RGB_BUF_SYNC_CHECK_EN
    logic        in_sob;
    logic        sync_err;
`endif

    int tests  = 0;
    int errors = 0;

    rgb_block_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
`ifdef RGB_BUF_SYNC_CHECK_EN
        .in_sob    (in_sob),
        .sync_err  (sync_err),
`endif
        .oR        (o_r),
        .oG        (o_g),
        .oB        (o_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_cnt   (blk_cnt)
    );

    // 10 time-unit clock; stimulus and sampling happen 1 unit after each rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pixel and hold it until it is accepted (bounded wait).
    task automatic push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic sob);
        int n;
        in_valid = 1'b1;
        in_r = r;
        in_g = g;
        in_b = b;
`ifdef RGB_BUF_SYNC_CHECK_EN
        in_sob = sob;
`else
        if (sob) begin
            in_r = r;
        end
`endif
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            tests++;
            errors++;
            $display("[TB] FAIL push_timeout: in_ready got %0b, expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
`ifdef RGB_BUF_SYNC_CHECK_EN
        in_sob = 1'b0;
`endif
    endtask

    task automatic test_reset();
        int bad;
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) begin
            push(8'(k + 1), 8'(k + 1), 8'(k + 1), k == 0);
        end
        #2;
        rst = 1'b1;
        #1;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (o_r[k] !== 8'd0 || o_g[k] !== 8'd0 || o_b[k] !== 8'd0) bad++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %0b, expected 1", in_ready);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %0b, expected 0", out_valid);
        end
        tests++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_zero: got %0d nonzero entries, expected 0", bad);
        end
        tests++;
        if (blk_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_blk_cnt: got %0d, expected 0", blk_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_reset_handshake: got out_valid=%0b in_ready=%0b, expected 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            push(8'(k), 8'(2 * k), 8'(255 - k), k == 0);
        end
        tests++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stream_out_valid: got %0b, expected 1", out_valid);
        end
        tests++;
        if (o_r[5] !== 8'd5 || o_g[5] !== 8'd10 || o_b[5] !== 8'd250) begin
            errors++;
            $display("[TB] FAIL stream_pixel5: got %0d/%0d/%0d, expected 5/10/250",
                     o_r[5], o_g[5], o_b[5]);
        end
        tests++;
        if (o_r[63] !== 8'd63 || o_g[63] !== 8'd126 || o_b[63] !== 8'd192) begin
            errors++;
            $display("[TB] FAIL stream_pixel63: got %0d/%0d/%0d, expected 63/126/192",
                     o_r[63], o_g[63], o_b[63]);
        end
        tick();
        tests++;
        if (blk_cnt !== 16'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_release: got blk_cnt=%0d out_valid=%0b, expected 1 0",
                     blk_cnt, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 128; k++) begin
            push((k < 64) ? 8'(k) : 8'(100 + k - 64), 8'(k), 8'(k), (k % 64) == 0);
        end
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL both_full: got in_ready=%0b out_valid=%0b, expected 0 1",
                     in_ready, out_valid);
        end
        tick();
        tick();
        tick();
        tests++;
        if (o_r[0] !== 8'd0 || o_r[63] !== 8'd63) begin
            errors++;
            $display("[TB] FAIL held_block_a: got oR[0]=%0d oR[63]=%0d, expected 0 63",
                     o_r[0], o_r[63]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (o_r[0] !== 8'd100 || o_r[63] !== 8'd163 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL switch_to_b: got oR[0]=%0d oR[63]=%0d in_ready=%0b, expected 100 163 1",
                     o_r[0], o_r[63], in_ready);
        end
        tests++;
        if (blk_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL backpressure_blk_cnt: got %0d, expected 2", blk_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int k = 0; k < 63; k++) begin
            push(8'(50 + k), 8'(k), 8'(k), k == 0);
        end
        out_ready = 1'b1;
        push(8'(50 + 63), 8'd63, 8'd63, 1'b0);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_out_valid: got %0b, expected 1", out_valid);
        end
        tests++;
        if (o_r[0] !== 8'd50 || o_r[63] !== 8'd113) begin
            errors++;
            $display("[TB] FAIL simul_new_block: got oR[0]=%0d oR[63]=%0d, expected 50 113",
                     o_r[0], o_r[63]);
        end
        tests++;
        if (blk_cnt !== 16'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_cnt_ready: got blk_cnt=%0d in_ready=%0b, expected 3 1",
                     blk_cnt, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (blk_cnt !== 16'd4 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_drain: got blk_cnt=%0d out_valid=%0b, expected 4 0",
                     blk_cnt, out_valid);
        end
    endtask

    task automatic test_reset_midblock();
        out_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            push(8'd99, 8'd99, 8'd99, k == 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 64; k++) begin
            push(8'(200 + k), 8'(k), 8'(k), k == 0);
        end
        tests++;
        if (o_r[0] !== 8'd200 || o_r[29] !== 8'd229 || o_r[63] !== 8'd7) begin
            errors++;
            $display("[TB] FAIL midreset_block: got oR[0]=%0d oR[29]=%0d oR[63]=%0d, expected 200 229 7",
                     o_r[0], o_r[29], o_r[63]);
        end
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || blk_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got out_valid=%0b in_ready=%0b blk_cnt=%0d, expected 1 1 0",
                     out_valid, in_ready, blk_cnt);
        end
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || blk_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midreset_one_block: got out_valid=%0b blk_cnt=%0d, expected 0 1",
                     out_valid, blk_cnt);
        end
    endtask

`ifdef RGB_BUF_SYNC_CHECK_EN
    task automatic test_sync_check();
        out_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            push(8'(k), 8'(k), 8'(k), k == 0);
        end
        tests++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sync_quiet: got %0b, expected 0", sync_err);
        end
        push(8'd40, 8'd40, 8'd40, 1'b1);
        tests++;
        if (sync_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sync_err_pulse: got %0b, expected 1", sync_err);
        end
        push(8'd41, 8'd41, 8'd41, 1'b0);
        tests++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sync_err_one_cycle: got %0b, expected 0", sync_err);
        end
        for (int k = 42; k < 104; k++) begin
            push(8'(k), 8'(k), 8'(k), 1'b0);
        end
        tests++;
        if (out_valid !== 1'b1 || o_r[0] !== 8'd40 || o_r[63] !== 8'd103) begin
            errors++;
            $display("[TB] FAIL sync_resync_block: got out_valid=%0b oR[0]=%0d oR[63]=%0d, expected 1 40 103",
                     out_valid, o_r[0], o_r[63]);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_r      = '0;
        in_g      = '0;
        in_b      = '0;
        out_ready = 1'b0;
`ifdef RGB_BUF_SYNC_CHECK_EN
        in_sob    = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_reset_midblock();
`ifdef RGB_BUF_SYNC_CHECK_EN
        test_sync_check();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
